ce_mrd_req_gen: RTL and testbench
=================================

Name: ce_mrd_req_gen

Overview:
- Host-read request initiator for the copy engine; drives the PCIe SS AXI-S TX request channel (txreq), which is otherwise unused.
- Accepts one read descriptor at a time: host address plus byte length.
- Splits each descriptor into single-beat MRd requests, respecting max read request size (MRRS) and 4 KB boundaries.
- Manages a pool of tags; the completion-side logic returns each tag when its read finishes.

Parameters:
- PCIE_DM_ENCODING, 0, 1 = data-mover header encoding, 0 = power-user encoding; drives tuser_vendor[0].
- CE_PF_ID, 4, PF number placed in the request header.
- CE_VF_ID, 0, VF number placed in the request header.
- CE_VF_ACTIVE, 0, vf_active bit in the request header.
- MRRS_BYTES, 512, maximum bytes per request; power of 2, range 128..4096.
- NUM_TAGS, 16, tag pool size; power of 2, at most 256.
- TAG_W, $clog2(NUM_TAGS), tag width.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- desc_valid  in  1  descriptor valid
- desc_ready  out  1  descriptor accepted when both valid and ready are high
- desc_src_addr  in  64  host byte address; bits [1:0] must be 0
- desc_len  in  24  byte length; bits [1:0] must be 0
- desc_done  out  1  one-cycle pulse when the last request of a descriptor is handshaken
- txreq_tvalid  out  1  request valid
- txreq_tready  in  1  request ready
- txreq_tdata  out  512  header in [255:0]; [511:256] driven to 0
- txreq_tkeep  out  64  constant 64'h0000_0000_FFFF_FFFF while valid, 0 otherwise
- txreq_tlast  out  1  always 1 while valid
- txreq_tuser_vendor  out  10  bit 0 = PCIE_DM_ENCODING; other bits 0
- cpl_free_valid  in  1  completion logic returns a tag
- cpl_free_tag  in  TAG_W  tag being returned
- busy  out  1  high when the FSM is not IDLE or any tag is outstanding
- err_align  out  1  sticky: a misaligned descriptor was accepted
- err_tag  out  1  sticky: a tag was freed that was not allocated

Behaviour:
- Reset (rst_n low at a clk edge):
  - all outputs 0;
  - FSM goes to IDLE;
  - tag bitmap cleared;
  - any in-flight request is dropped; tvalid goes low the cycle after reset is sampled.
- FSM states:
  - IDLE: desc_ready=1. On accept, latch addr and len.
    - If len==0: desc_done pulses in the next cycle; stay IDLE.
    - Else go to CALC.
    - If addr[1:0] or len[1:0] is nonzero: set err_align, zero those bits, continue.
  - CALC: compute chunk = min(rem, MRRS_BYTES, 4096 - addr[11:0]).
    - If a tag is free: allocate the lowest-index free tag, register the header, go to ISSUE.
    - Else stay in CALC (tag stall).
  - ISSUE: txreq_tvalid=1; header held stable until txreq_tready.
    - On handshake: addr += chunk; rem -= chunk.
    - If rem==0: pulse desc_done and go to IDLE; else go to CALC.
- Latency: descriptor accepted in cycle N → CALC in N+1 → tvalid in N+2 when a tag is free. Sustained rate is one request per 2 cycles.
- Header fields, bit layout in ce_mrd_pkg:
  - fmt_type = 8'h20 (MRd, 4DW);
  - length_dw = chunk/4; value 0 encodes 1024 DW;
  - tag;
  - host_addr[63:2];
  - req_id = {pf, vf, vf_active};
  - first_be = 4'hF;
  - last_be = 4'hF when length_dw > 1, 4'h0 when length_dw == 1.
- Tag bitmap:
  - set on allocation in CALC;
  - cleared on cpl_free_valid.
  - Freeing a tag that is not allocated sets err_tag; bitmap unchanged.
  - Free and allocation in the same cycle: the free is applied first, so the freed tag is eligible for that same allocation.
- Address arithmetic is 64-bit. Wrap past 2^64 is not checked.
- desc_done is issue-done, not data-done; busy covers outstanding tags.

Decomposition:
- ce_mrd_pkg holds:
  - t_ce_mrd_hdr packed struct (256 b);
  - MRD_FMT_TYPE = 8'h20;
  - TXREQ_KEEP_HDR constant;
  - t_mrd_state enum.
- Sub-module ce_tag_pool:
  - bitmap plus lowest-free priority encoder;
  - ports alloc_req, alloc_tag, alloc_ok, free_valid, free_tag, free_err, any_busy.

Test Plan:
- Descriptor addr=0x1000, len=0x600, tready=1, MRRS=512 → three requests:
  - 0x1000/128DW, tag0;
  - 0x1200/128DW, tag1;
  - 0x1400/128DW, tag2;
  - desc_done coincides with the 3rd handshake.
- Descriptor addr=0xF80, len=0x100 → 0xF80/32DW then 0x1000/32DW; split at the 4 KB boundary.
- NUM_TAGS=16, no frees, descriptor len=0x2400 → 16 requests issued, then FSM stalls in CALC. Free tag 5 → next request carries tag 5.
- tready held low for 10 cycles in ISSUE → tvalid and tdata stable throughout; exactly one request counted.
- len=0 → desc_done 1 cycle after accept, no txreq traffic. Free of an unallocated tag 3 → err_tag=1, stays sticky.
- rst_n low for 1 cycle mid-ISSUE → next cycle tvalid=0, busy=0, desc_ready=1; after the next descriptor the first tag is 0.

Source files
------------

// File: rtl/ce_mrd_pkg.sv
// Shared types and constants for the copy-engine host-read request generator.
package ce_mrd_pkg;

    localparam int unsigned HDR_W   = 256;
    localparam int unsigned TDATA_W = 512;
    localparam int unsigned KEEP_W  = 64;

    localparam logic [7:0]        MRD_FMT_TYPE   = 8'h20;
    localparam logic [KEEP_W-1:0] TXREQ_KEEP_HDR = 64'h0000_0000_FFFF_FFFF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CALC  = 2'd1,
        ST_ISSUE = 2'd2
    } t_mrd_state;

    // MRd request header; fmt_type occupies the least significant byte
    typedef struct packed {
        logic [142:0] rsvd;
        logic [2:0]   pf_num;
        logic [10:0]  vf_num;
        logic         vf_active;
        logic [61:0]  host_addr;
        logic [1:0]   addr_rsvd;
        logic [3:0]   last_be;
        logic [3:0]   first_be;
        logic [7:0]   tag;
        logic [9:0]   length_dw;
        logic [7:0]   fmt_type;
    } t_ce_mrd_hdr;

    // A single-DW read has no last DW, so its last byte enable must be zero
    function automatic logic [3:0] last_be_for(input logic [9:0] len_dw);
        return (len_dw == 10'd1) ? 4'h0 : 4'hF;
    endfunction

endpackage

// File: rtl/ce_tag_pool.sv
// Tag bitmap with lowest-index-free allocation; a same-cycle free is applied
// before allocation so the returned tag can be handed straight back out.
module ce_tag_pool #(
    parameter int unsigned NUM_TAGS = 16,
    parameter int unsigned TAG_W    = $clog2(NUM_TAGS)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_alloc_req,
    output logic [TAG_W-1:0] o_alloc_tag_c,
    output logic             o_alloc_ok_c,
    input  logic             i_free_valid,
    input  logic [TAG_W-1:0] i_free_tag,
    output logic             o_free_err_c,
    output logic             o_any_busy_c
);

    logic [NUM_TAGS-1:0] r_bitmap;
    logic [NUM_TAGS-1:0] w_after_free;
    logic [NUM_TAGS-1:0] w_bitmap_nxt;

    // o_any_busy_c reflects the bitmap as it will be after this cycle's updates
    always_comb begin
        w_after_free  = r_bitmap;
        o_free_err_c  = 1'b0;
        o_alloc_ok_c  = 1'b0;
        o_alloc_tag_c = '0;
        if (i_free_valid) begin
            if (r_bitmap[i_free_tag]) begin
                w_after_free[i_free_tag] = 1'b0;
            end else begin
                o_free_err_c = 1'b1;
            end
        end
        for (int i = NUM_TAGS - 1; i >= 0; i--) begin
            if (!w_after_free[i]) begin
                o_alloc_ok_c  = 1'b1;
                o_alloc_tag_c = TAG_W'(i);
            end
        end
        w_bitmap_nxt = w_after_free;
        if (i_alloc_req && o_alloc_ok_c) begin
            w_bitmap_nxt[o_alloc_tag_c] = 1'b1;
        end
        o_any_busy_c = |w_bitmap_nxt;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_bitmap <= '0;
        end else begin
            r_bitmap <= w_bitmap_nxt;
        end
    end

endmodule

// File: rtl/ce_mrd_req_gen.sv
// Host-read request initiator: splits one descriptor at a time into MRd
// requests bounded by MRRS and 4 KB pages, each carrying a pooled tag.
module ce_mrd_req_gen
    import ce_mrd_pkg::*;
#(
    parameter int unsigned PCIE_DM_ENCODING = 0,
    parameter int unsigned CE_PF_ID         = 4,
    parameter int unsigned CE_VF_ID         = 0,
    parameter int unsigned CE_VF_ACTIVE     = 0,
    parameter int unsigned MRRS_BYTES       = 512,
    parameter int unsigned NUM_TAGS         = 16,
    parameter int unsigned TAG_W            = $clog2(NUM_TAGS)
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_desc_valid,
    output logic               o_desc_ready,
    input  logic [63:0]        i_desc_src_addr,
    input  logic [23:0]        i_desc_len,
    output logic               o_desc_done,
    output logic               o_txreq_tvalid,
    input  logic               i_txreq_tready,
    output logic [TDATA_W-1:0] o_txreq_tdata,
    output logic [KEEP_W-1:0]  o_txreq_tkeep,
    output logic               o_txreq_tlast,
    output logic [9:0]         o_txreq_tuser_vendor,
    input  logic               i_cpl_free_valid,
    input  logic [TAG_W-1:0]   i_cpl_free_tag,
    output logic               o_busy,
    output logic               o_err_align,
    output logic               o_err_tag
);

    localparam int unsigned CHUNK_W = 13;

    t_mrd_state         r_state;
    logic [63:0]        r_addr;
    logic [23:0]        r_rem;
    logic [CHUNK_W-1:0] r_chunk;
    t_ce_mrd_hdr        r_hdr;
    logic               r_desc_ready;
    logic               r_desc_done;
    logic               r_tvalid;
    logic [KEEP_W-1:0]  r_tkeep;
    logic               r_tlast;
    logic [9:0]         r_tuser;
    logic               r_busy;
    logic               r_err_align;
    logic               r_err_tag;

    logic               w_alloc_req;
    logic [TAG_W-1:0]   w_alloc_tag;
    logic               w_alloc_ok;
    logic               w_free_err;
    logic               w_pool_busy;
    logic               w_accept;
    logic [CHUNK_W-1:0] w_to_4k;
    logic [CHUNK_W-1:0] w_rem_clip;
    logic [CHUNK_W-1:0] w_chunk;
    logic [9:0]         w_len_dw;
    t_ce_mrd_hdr        w_hdr;

    assign w_alloc_req = (r_state == ST_CALC);
    assign w_accept    = (r_state == ST_IDLE) && r_desc_ready && i_desc_valid;

    ce_tag_pool #(
        .NUM_TAGS (NUM_TAGS),
        .TAG_W    (TAG_W)
    ) u_tag_pool (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .i_alloc_req   (w_alloc_req),
        .o_alloc_tag_c (w_alloc_tag),
        .o_alloc_ok_c  (w_alloc_ok),
        .i_free_valid  (i_cpl_free_valid),
        .i_free_tag    (i_cpl_free_tag),
        .o_free_err_c  (w_free_err),
        .o_any_busy_c  (w_pool_busy)
    );

    // chunk = min(remaining, MRRS, bytes left in the current 4 KB page)
    always_comb begin
        w_to_4k    = CHUNK_W'(13'h1000 - {1'b0, r_addr[11:0]});
        w_rem_clip = (r_rem > 24'(MRRS_BYTES)) ? CHUNK_W'(MRRS_BYTES) : CHUNK_W'(r_rem);
        w_chunk    = (w_rem_clip < w_to_4k) ? w_rem_clip : w_to_4k;
        w_len_dw   = 10'(w_chunk >> 2);
    end

    always_comb begin
        w_hdr           = '0;
        w_hdr.fmt_type  = MRD_FMT_TYPE;
        w_hdr.length_dw = w_len_dw;
        w_hdr.tag       = 8'(w_alloc_tag);
        w_hdr.first_be  = 4'hF;
        w_hdr.last_be   = last_be_for(w_len_dw);
        w_hdr.host_addr = r_addr[63:2];
        w_hdr.pf_num    = 3'(CE_PF_ID);
        w_hdr.vf_num    = 11'(CE_VF_ID);
        w_hdr.vf_active = 1'(CE_VF_ACTIVE);
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state      <= ST_IDLE;
            r_addr       <= '0;
            r_rem        <= '0;
            r_chunk      <= '0;
            r_hdr        <= '0;
            r_desc_ready <= 1'b0;
            r_desc_done  <= 1'b0;
            r_tvalid     <= 1'b0;
            r_tkeep      <= '0;
            r_tlast      <= 1'b0;
            r_tuser      <= '0;
            r_busy       <= 1'b0;
            r_err_align  <= 1'b0;
            r_err_tag    <= 1'b0;
        end else begin
            r_desc_done <= 1'b0;
            r_busy      <= w_pool_busy;
            r_tuser     <= {9'b0, 1'(PCIE_DM_ENCODING)};
            if (w_free_err) begin
                r_err_tag <= 1'b1;
            end
            case (r_state)
                ST_IDLE: begin
                    r_desc_ready <= 1'b1;
                    if (w_accept) begin
                        r_addr <= {i_desc_src_addr[63:2], 2'b00};
                        r_rem  <= {i_desc_len[23:2], 2'b00};
                        if ((i_desc_src_addr[1:0] != 2'b00) || (i_desc_len[1:0] != 2'b00)) begin
                            r_err_align <= 1'b1;
                        end
                        if (i_desc_len[23:2] == 22'd0) begin
                            r_desc_done <= 1'b1;
                        end else begin
                            r_state      <= ST_CALC;
                            r_desc_ready <= 1'b0;
                            r_busy       <= 1'b1;
                        end
                    end
                end
                ST_CALC: begin
                    r_busy <= 1'b1;
                    if (w_alloc_ok) begin
                        r_hdr    <= w_hdr;
                        r_chunk  <= w_chunk;
                        r_tvalid <= 1'b1;
                        r_tkeep  <= TXREQ_KEEP_HDR;
                        r_tlast  <= 1'b1;
                        r_state  <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (i_txreq_tready) begin
                        r_tvalid <= 1'b0;
                        r_tkeep  <= '0;
                        r_tlast  <= 1'b0;
                        r_addr   <= r_addr + 64'(r_chunk);
                        r_rem    <= r_rem - 24'(r_chunk);
                        if (r_rem == 24'(r_chunk)) begin
                            r_desc_done  <= 1'b1;
                            r_desc_ready <= 1'b1;
                            r_state      <= ST_IDLE;
                        end else begin
                            r_busy  <= 1'b1;
                            r_state <= ST_CALC;
                        end
                    end else begin
                        r_busy <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_desc_ready         = r_desc_ready;
    assign o_desc_done          = r_desc_done;
    assign o_txreq_tvalid       = r_tvalid;
    assign o_txreq_tdata        = {256'b0, r_hdr};
    assign o_txreq_tkeep        = r_tkeep;
    assign o_txreq_tlast        = r_tlast;
    assign o_txreq_tuser_vendor = r_tuser;
    assign o_busy               = r_busy;
    assign o_err_align          = r_err_align;
    assign o_err_tag            = r_err_tag;

endmodule

// File: tb/tb_ce_mrd_req_gen.sv
// Directed bench for ce_mrd_req_gen with a request scoreboard.
module tb_ce_mrd_req_gen;
    import ce_mrd_pkg::*;

    localparam int unsigned TAG_W = 4;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               desc_valid;
    logic               desc_ready;
    logic [63:0]        desc_src_addr;
    logic [23:0]        desc_len;
    logic               desc_done;
    logic               txreq_tvalid;
    logic               txreq_tready;
    logic [511:0]       txreq_tdata;
    logic [63:0]        txreq_tkeep;
    logic               txreq_tlast;
    logic [9:0]         txreq_tuser_vendor;
    logic               cpl_free_valid;
    logic [TAG_W-1:0]   cpl_free_tag;
    logic               busy;
    logic               err_align;
    logic               err_tag;

    always #5 clk = ~clk;

    ce_mrd_req_gen dut (
        .i_clk                (clk),
        .i_rst_n              (rst_n),
        .i_desc_valid         (desc_valid),
        .o_desc_ready         (desc_ready),
        .i_desc_src_addr      (desc_src_addr),
        .i_desc_len           (desc_len),
        .o_desc_done          (desc_done),
        .o_txreq_tvalid       (txreq_tvalid),
        .i_txreq_tready       (txreq_tready),
        .o_txreq_tdata        (txreq_tdata),
        .o_txreq_tkeep        (txreq_tkeep),
        .o_txreq_tlast        (txreq_tlast),
        .o_txreq_tuser_vendor (txreq_tuser_vendor),
        .i_cpl_free_valid     (cpl_free_valid),
        .i_cpl_free_tag       (cpl_free_tag),
        .o_busy               (busy),
        .o_err_align          (err_align),
        .o_err_tag            (err_tag)
    );

    typedef struct {
        logic [255:0] hdr;
        bit           last;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   hs_cnt   = 0;
    bit   pend_done = 1'b0;

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] mk_hdr(input logic [63:0] a, input int unsigned bytes,
                                            input int unsigned tag);
        t_ce_mrd_hdr h;
        h           = '0;
        h.fmt_type  = 8'h20;
        h.length_dw = 10'(bytes / 4);
        h.tag       = 8'(tag);
        h.first_be  = 4'hF;
        h.last_be   = (bytes == 4) ? 4'h0 : 4'hF;
        h.host_addr = a[63:2];
        h.pf_num    = 3'd4;
        h.vf_num    = 11'd0;
        h.vf_active = 1'b0;
        return h;
    endfunction

    task automatic push_req(input logic [63:0] a, input int unsigned bytes,
                            input int unsigned tag, input bit last);
        exp_t e;
        e.hdr  = mk_hdr(a, bytes, tag);
        e.last = last;
        q.push_back(e);
    endtask

    // Scoreboard: done pulses and accepted requests, sampled mid-cycle
    always @(negedge clk) begin
        exp_t e;
        if (pend_done || desc_done) chk("desc_done", 512'(desc_done), 512'(pend_done));
        pend_done = 1'b0;
        if (rst_n && txreq_tvalid && txreq_tready) begin
            hs_cnt++;
            n_checks++;
            assert (q.size() != 0) begin
                n_pass++;
            end else begin
                $error("FAIL unexpected_req: observed hdr %0h expected no request", txreq_tdata[255:0]);
            end
            if (q.size() != 0) begin
                e = q.pop_front();
                chk("hdr", 512'(txreq_tdata[255:0]), 512'(e.hdr));
                chk("tdata_hi", 512'(txreq_tdata[511:256]), 512'(0));
                chk("tkeep", 512'(txreq_tkeep), 512'(64'h0000_0000_FFFF_FFFF));
                chk("tlast", 512'(txreq_tlast), 512'(1));
                chk("tuser", 512'(txreq_tuser_vendor), 512'(0));
                if (e.last) pend_done = 1'b1;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_desc(input logic [63:0] a, input logic [23:0] l);
        int k = 0;
        desc_valid    = 1'b1;
        desc_src_addr = a;
        desc_len      = l;
        while (desc_ready !== 1'b1 && k < 200) begin
            step();
            k++;
        end
        chk("desc_accept_timeout", 512'(k < 200), 512'(1));
        step();
        desc_valid = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int k = 0;
        while ((q.size() != 0 || pend_done) && k < budget) begin
            step();
            k++;
        end
        chk("drain_timeout", 512'(k < budget), 512'(1));
    endtask

    task automatic wait_hs(input int target, input int budget);
        int k = 0;
        while (hs_cnt < target && k < budget) begin
            step();
            k++;
        end
        chk("hs_timeout", 512'(hs_cnt >= target), 512'(1));
    endtask

    task automatic wait_tvalid(input int budget);
        int k = 0;
        while (txreq_tvalid !== 1'b1 && k < budget) begin
            step();
            k++;
        end
        chk("tvalid_timeout", 512'(k < budget), 512'(1));
    endtask

    task automatic free_tag(input int unsigned t);
        cpl_free_valid = 1'b1;
        cpl_free_tag   = TAG_W'(t);
        step();
        cpl_free_valid = 1'b0;
    endtask

    initial begin
        int h0;
        rst_n          = 1'b0;
        desc_valid     = 1'b0;
        desc_src_addr  = '0;
        desc_len       = '0;
        txreq_tready   = 1'b1;
        cpl_free_valid = 1'b0;
        cpl_free_tag   = '0;
        repeat (3) step();

        // reset state: every output low
        chk("rst_ready", 512'(desc_ready), 512'(0));
        chk("rst_tvalid", 512'(txreq_tvalid), 512'(0));
        chk("rst_busy", 512'(busy), 512'(0));
        chk("rst_tkeep", 512'(txreq_tkeep), 512'(0));
        chk("rst_errs", 512'({err_align, err_tag}), 512'(0));
        rst_n = 1'b1;
        step();
        chk("idle_ready", 512'(desc_ready), 512'(1));

        // three MRRS-sized requests, tags 0..2
        push_req(64'h1000, 512, 0, 1'b0);
        push_req(64'h1200, 512, 1, 1'b0);
        push_req(64'h1400, 512, 2, 1'b1);
        send_desc(64'h1000, 24'h600);
        chk("lat_calc_tvalid", 512'(txreq_tvalid), 512'(0));
        step();
        chk("lat_issue_tvalid", 512'(txreq_tvalid), 512'(1));
        wait_drain(100);
        chk("busy_tags_held", 512'(busy), 512'(1));
        for (int t = 0; t < 3; t++) free_tag(t);
        chk("busy_after_free", 512'(busy), 512'(0));

        // 4 KB boundary split
        push_req(64'hF80, 128, 0, 1'b0);
        push_req(64'h1000, 128, 1, 1'b1);
        send_desc(64'hF80, 24'h100);
        wait_drain(100);
        free_tag(0);
        free_tag(1);

        // backpressure: header stays put while tready is low
        txreq_tready = 1'b0;
        push_req(64'h2000, 128, 0, 1'b1);
        send_desc(64'h2000, 24'h80);
        wait_tvalid(20);
        h0 = hs_cnt;
        for (int i = 0; i < 10; i++) begin
            chk("stall_tvalid", 512'(txreq_tvalid), 512'(1));
            chk("stall_tdata", 512'(txreq_tdata[255:0]), 512'(mk_hdr(64'h2000, 128, 0)));
            step();
        end
        txreq_tready = 1'b1;
        wait_drain(100);
        chk("stall_one_req", 512'(hs_cnt), 512'(h0 + 1));
        free_tag(0);

        // zero-length descriptor and an invalid tag free
        h0 = hs_cnt;
        send_desc(64'h3000, 24'h0);
        pend_done = 1'b1;
        repeat (3) step();
        chk("zero_len_no_req", 512'(hs_cnt), 512'(h0));
        chk("err_tag_clear", 512'(err_tag), 512'(0));
        free_tag(3);
        chk("err_tag_set", 512'(err_tag), 512'(1));
        repeat (5) step();
        chk("err_tag_sticky", 512'(err_tag), 512'(1));

        // misaligned descriptor: low bits dropped, error flagged
        push_req(64'h3000, 64, 0, 1'b1);
        send_desc(64'h3002, 24'h42);
        chk("err_align_set", 512'(err_align), 512'(1));
        wait_drain(100);
        free_tag(0);

        // tag exhaustion: 16 requests, stall, then freed tags reused
        h0 = hs_cnt;
        for (int k = 0; k < 16; k++) push_req(64'h10000 + 64'(512 * k), 512, k, 1'b0);
        send_desc(64'h10000, 24'h2400);
        wait_hs(h0 + 16, 200);
        repeat (5) step();
        chk("exhaust_no_tvalid", 512'(txreq_tvalid), 512'(0));
        chk("exhaust_busy", 512'(busy), 512'(1));
        chk("exhaust_count", 512'(hs_cnt), 512'(h0 + 16));
        push_req(64'h10000 + 64'(512 * 16), 512, 5, 1'b0);
        push_req(64'h10000 + 64'(512 * 17), 512, 9, 1'b1);
        free_tag(5);
        wait_hs(h0 + 17, 50);
        free_tag(9);
        wait_drain(100);
        for (int t = 0; t < 16; t++) free_tag(t);
        chk("all_freed_busy", 512'(busy), 512'(0));
        chk("no_spurious_err", 512'(err_tag), 512'(1));

        // reset mid-ISSUE drops the request and restarts tags from 0
        txreq_tready = 1'b0;
        push_req(64'h4000, 512, 0, 1'b0);
        send_desc(64'h4000, 24'h200);
        wait_tvalid(20);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        q.delete();
        pend_done = 1'b0;
        chk("midrst_tvalid", 512'(txreq_tvalid), 512'(0));
        chk("midrst_busy", 512'(busy), 512'(0));
        chk("midrst_err_tag", 512'(err_tag), 512'(0));
        step();
        chk("midrst_ready", 512'(desc_ready), 512'(1));
        txreq_tready = 1'b1;
        push_req(64'h5000, 128, 0, 1'b1);
        send_desc(64'h5000, 24'h80);
        wait_drain(100);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
